imem_boot_ctrl: RTL
===================

# imem_boot_ctrl

Boot-load controller and port arbiter for the single-ported instruction memory. After reset it streams program words from a valid/ready load interface into consecutive IMEM words while holding the core stalled. On completion it hands the memory port to the core's fetch path. A reload request returns it to load mode without a chip reset.

## Interface

Parameters:

- `MEM_DEPTH_WORDS`, default 4096: IMEM depth in 32-bit words; power of two, at least 4.
- `CW`, default `$clog2(MEM_DEPTH_WORDS)+1`: width of `word_count`.

Ports:

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ld_valid` input 1: load word present.
- `ld_ready` output 1: controller accepts a load word.
- `ld_data` input 32: program word.
- `ld_last` input 1: qualifies the final word of a load.
- `reload_req` input 1: single-cycle pulse requesting a new load.
- `cpu_addr` input 32: core fetch byte address (PC).
- `cpu_instr` output 32: instruction returned to the core.
- `cpu_stall` output 1: core must hold its PC.
- `mem_addr` output 32: byte address to IMEM; IMEM indexes with `addr[31:2]`.
- `mem_we` output 1: IMEM write enable.
- `mem_wdata` output 32: IMEM write data.
- `mem_rdata` input 32: IMEM combinational read data.
- `boot_done` output 1: a load has completed and the core is running.
- `load_err` output 1: the last load overflowed without `ld_last`.
- `word_count` output CW: number of words accepted in the current or most recent load.
- `checksum` output 32: sum of loaded words (see Configuration).

## Operation

The state machine has two states, `LOAD` and `RUN`. Reset enters `LOAD`.

**LOAD**

- `ld_ready=1`, `cpu_stall=1`, `cpu_instr=32'h00000013` (NOP).
- `mem_addr = {word_count, 2'b00}` zero-extended to 32 bits.
- `mem_wdata = ld_data`.
- `mem_we = ld_valid`.
- An accept is `ld_valid && ld_ready`. On each accept, `word_count` increments.
- Accept with `ld_last=1`: next state is `RUN`, `boot_done` goes to 1, `load_err` goes to 0.
- Accept without `ld_last` at index `MEM_DEPTH_WORDS-1`: next state is `RUN`, `boot_done` goes to 1, `load_err` goes to 1. The write to the final word still occurs. No wrap to index 0 ever occurs.
- `reload_req` is ignored in this state.

**RUN**

- `ld_ready=0`, `mem_we=0`, `cpu_stall=0`.
- `mem_addr = cpu_addr` and `cpu_instr = mem_rdata`. Both paths are combinational.
- `ld_valid` is ignored; no write occurs.
- `reload_req=1` causes the next state to be `LOAD`. On that transition `word_count`, `checksum`, `boot_done` and `load_err` clear to 0.

**Width rules**

- `word_count` saturates at `MEM_DEPTH_WORDS`.
- `checksum` uses modulo-2^32 addition.

## Timing

Reset values:

- State `LOAD`.
- `word_count=0`, `checksum=0`, `boot_done=0`, `load_err=0`.
- Combinational outputs follow the `LOAD` rules: `ld_ready=1`, `cpu_stall=1`, `cpu_instr=NOP`.
- IMEM contents are not cleared.

Cycle behaviour:

- Write latency is zero. The word is written on the same edge it is accepted.
- Throughput is one word per cycle. Gaps in `ld_valid` are allowed and do not advance `word_count`.
- `RUN` outputs take effect in the cycle after the accept of the final word.
- `LOAD` outputs take effect in the cycle after `reload_req`.
- Reset asserted mid-load aborts the load immediately and asynchronously: state returns to `LOAD` with the count at 0. Partially written memory is retained and is overwritten by the next load.
- `reload_req` asserted in the same cycle as the final accept is ignored, because the state is still `LOAD`.
- Fetch path in `RUN` is purely combinational, with no added latency relative to a direct IMEM connection.

## Configuration

Macro: `IMEM_BOOT_CHECKSUM_EN`.

- **Defined:** `checksum` accumulates `ld_data` on every accept and clears on reset and on reload entry. It holds its value in `RUN`.
- **Undefined:** `checksum` is tied to `32'h0`, and no accumulator register is synthesized.

## Test plan

1. **Basic load and fetch.**
   - Stimulus: reset, then stream 21 words `00000013, 00a00093, … fe0006e3`, with `ld_last` on the 21st.
   - Required: `word_count=21`, then `boot_done=1` and `cpu_stall=0` one cycle after the final accept.
   - Fetch checks: `cpu_addr=0x50` returns `fe0006e3`; `cpu_addr=0x05` returns `00a00093`.
2. **Stall and backpressure.**
   - Stimulus: drive `cpu_addr=0x04` during load, with `ld_valid` gapped as 1,0,0,1.
   - Required: `cpu_instr=00000013` and `cpu_stall=1` throughout the load. `word_count` advances only on valid cycles, and only accepted words land at consecutive indices.
3. **Overflow.**
   - Stimulus: `MEM_DEPTH_WORDS=8`, send 10 words with no `ld_last`.
   - Required: 8 words accepted; `word_count=8`, `load_err=1`, `boot_done=1`. Words 9 and 10 see `ld_ready=0`, and word index 0 is unchanged.
4. **Reload.**
   - Stimulus: in `RUN`, pulse `reload_req`, then load 2 words `DEADBEEF, 12345737` with `ld_last` on the 2nd.
   - Required: `boot_done=0` the cycle after the pulse. After the load, `word_count=2`, address `0x0` returns `DEADBEEF`, and address `0x8` retains the old word.
5. **Reset mid-load.**
   - Stimulus: assert `rst_n=0` asynchronously after 5 accepted words.
   - Required: `word_count=0` and `ld_ready=1` immediately, without waiting for a clock edge. The next load writes from index 0.
6. **Checksum (`IMEM_BOOT_CHECKSUM_EN` defined).**
   - Stimulus: load `FFFFFFFF, 00000002`.
   - Required: `checksum=00000001` (the sum wraps).
   - Without the macro: `checksum=0`.

Source files
------------

// File: rtl/imem_boot_ctrl_if.sv
// imem_boot_ctrl_if: load stream, core fetch port and IMEM port of the boot controller.
// Latency: none, plain wires only.
// Backpressure: ld_ready is driven by the controller; slave = controller view, master = environment view.
interface imem_boot_ctrl_if;
    // load stream
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;
    // core fetch path
    logic [31:0] cpu_addr;
    logic [31:0] cpu_instr;
    logic        cpu_stall;
    // single IMEM port (byte address, IMEM indexes with addr[31:2])
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  ld_valid, ld_data, ld_last, cpu_addr, mem_rdata,
        output ld_ready, cpu_instr, cpu_stall, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output ld_valid, ld_data, ld_last, cpu_addr, mem_rdata,
        input  ld_ready, cpu_instr, cpu_stall, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: boot loader + port arbiter for the single-ported IMEM (LOAD streams words in, RUN hands port to fetch).
// Latency: load word written on its accept edge; RUN/LOAD outputs change the cycle after final accept / reload_req.
// Backpressure: ld_ready=1 throughout LOAD, 0 in RUN; one word per cycle, ld_valid gaps allowed.
//
// Ports: clk, rst_n (async active-low); bus (imem_boot_ctrl_if.slave: ld_*, cpu_*, mem_*);
//        reload_req (pulse, RUN only); boot_done, load_err, word_count, checksum status outputs.
// Optional feature: define IMEM_BOOT_CHECKSUM_EN to build the modulo-2^32 checksum of loaded
// words; without it checksum is constant zero and no accumulator exists.
module imem_boot_ctrl #(
    parameter int MEM_DEPTH_WORDS = 4096,
    parameter int CW              = $clog2(MEM_DEPTH_WORDS) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    imem_boot_ctrl_if.slave       bus,
    input  logic                  reload_req,
    output logic                  boot_done,
    output logic                  load_err,
    output logic [CW-1:0]         word_count,
    output logic [31:0]           checksum
);

    localparam logic [31:0]   NOP      = 32'h0000_0013;
    localparam logic [CW-1:0] LAST_IDX = CW'(MEM_DEPTH_WORDS - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(MEM_DEPTH_WORDS);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt_q;
    logic          boot_done_q;
    logic          load_err_q;
    logic          accept;

    // ld_ready is exactly "in LOAD", so an accept is valid while loading.
    assign accept = bus.ld_valid && (state == S_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_LOAD;
            cnt_q       <= '0;
            boot_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        if (cnt_q != FULL_CNT) begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                        if (bus.ld_last) begin
                            state       <= S_RUN;
                            boot_done_q <= 1'b1;
                            load_err_q  <= 1'b0;
                        end else if (cnt_q == LAST_IDX) begin
                            // Memory is full without a terminating word: stop here rather than wrap.
                            state       <= S_RUN;
                            boot_done_q <= 1'b1;
                            load_err_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (reload_req) begin
                        state       <= S_LOAD;
                        cnt_q       <= '0;
                        boot_done_q <= 1'b0;
                        load_err_q  <= 1'b0;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [31:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= 32'h0;
        end else if (accept) begin
            csum_q <= csum_q + bus.ld_data;
        end else if ((state == S_RUN) && reload_req) begin
            csum_q <= 32'h0;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = 32'h0;
`endif

    // Port mux: load writes at the running word index, otherwise the core owns the address.
    logic        in_load;
    assign in_load = (state == S_LOAD);

    assign bus.ld_ready  = in_load;
    assign bus.cpu_stall = in_load;
    assign bus.mem_we    = in_load && bus.ld_valid;
    assign bus.mem_wdata = bus.ld_data;
    assign bus.mem_addr  = in_load ? 32'({cnt_q, 2'b00}) : bus.cpu_addr;
    assign bus.cpu_instr = in_load ? NOP : bus.mem_rdata;

    assign boot_done  = boot_done_q;
    assign load_err   = load_err_q;
    assign word_count = cnt_q;

endmodule
